// File: rtl/icache_line_reader.sv
// One-line instruction fetch buffer: serves hits from a registered line, refills the whole line on a miss.
// Latency: a hit returns the word 1 cycle after it is accepted; a miss with back-to-back beats stalls for WORDS+1 cycles.
// Backpressure: busywait stalls the CPU combinationally; memory beats are accepted whenever mem_rvalid is high.
module icache_line_reader #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               read,
    input  logic [ADDR_W-1:0]                  address,
    input  logic                               flush,
    output logic                               busywait,
    output logic [WORD_W-1:0]                  instruction,
    output logic                               instr_valid,
    output logic                               mem_read,
    output logic [ADDR_W-$clog2(WORDS)-1:0]    mem_address,
    input  logic                               mem_rvalid,
    input  logic [WORD_W-1:0]                  mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  line [WORDS];
    logic [TAG_W-1:0]   tag;
    logic               valid;
    logic [OFF_W-1:0]   beat;

    logic [TAG_W-1:0]   addr_tag;
    logic [OFF_W-1:0]   addr_off;
    logic               hit;
    logic               last_beat;

    assign addr_tag  = address[ADDR_W-1:OFF_W];
    assign addr_off  = address[OFF_W-1:0];
    // A flush in the same cycle wins over a hit so a stale line is never served.
    assign hit       = (state == IDLE) & valid & (tag == addr_tag) & ~flush;
    assign busywait  = read & ~hit;
    assign last_beat = mem_rvalid & (beat == LAST_BEAT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (read && !hit) state_nxt = FILL;
            FILL: if (flush || last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tag         <= '0;
            valid       <= 1'b0;
            beat        <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            state       <= state_nxt;
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) valid <= 1'b0;
                    if (read && hit) begin
                        instruction <= line[addr_off];
                        instr_valid <= 1'b1;
                    end else if (read) begin
                        mem_address <= addr_tag;
                        mem_read    <= 1'b1;
                        beat        <= '0;
                        valid       <= 1'b0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        mem_read <= 1'b0;
                        beat     <= '0;
                    end else if (mem_rvalid) begin
                        beat <= beat + OFF_W'(1);
                        if (beat == LAST_BEAT) begin
                            tag      <= mem_address;
                            valid    <= 1'b1;
                            mem_read <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage is data-only; valid gates its use, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state == FILL && mem_rvalid && !flush)
            line[beat] <= mem_rdata;
    end

endmodule

// File: doc/icache_line_reader.md
# icache_line_reader

Parametrised instruction-fetch line buffer that replaces the fixed 4-to-1 word-select mux in the instruction cache read path. It holds one cache line of `WORDS` instruction words plus its tag and valid bit. On a fetch it returns the selected word from the line on a hit. On a miss it refills the whole line from instruction memory as a word-per-cycle burst, then serves the request. It sits between the CPU fetch stage and the instruction memory and drives the CPU `busywait`.

## Interface
- `WORD_W`, 32: instruction word width in bits.
- `WORDS`, 4: words per line; must be a power of 2, ≥2. `OFF_W = $clog2(WORDS)`.
- `ADDR_W`, 10: fetch word-address width. Tag = `address[ADDR_W-1:OFF_W]`; offset = `address[OFF_W-1:0]`.
- `clock`  in  1  single clock for all state, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read`  in  1  fetch request, level; held by the CPU until `busywait` is low.
- `address`  in  ADDR_W  fetch word address.
- `flush`  in  1  one-cycle pulse that invalidates the line.
- `busywait`  out  1  combinational stall to the CPU.
- `instruction`  out  WORD_W  registered fetched word.
- `instr_valid`  out  1  registered; pulses for 1 cycle after an accepted hit.
- `mem_read`  out  1  registered burst request to instruction memory.
- `mem_address`  out  ADDR_W-OFF_W  registered line address of the burst.
- `mem_rvalid`  in  1  memory beat strobe; one word per asserted cycle, in offset order 0..WORDS-1.
- `mem_rdata`  in  WORD_W  beat data.

## Operation
- State: `line[0..WORDS-1]`, `tag`, `valid`, `beat` (OFF_W bits), FSM `{IDLE, FILL}`.
- Hit definition: `hit = (state==IDLE) & valid & (tag == address tag)`.
- Stall rule: `busywait = read & ~hit` (combinational).
- IDLE, `read & hit`:
  - At the edge, `instruction <= line[offset]` and `instr_valid <= 1`.
  - Stay in IDLE. Back-to-back hits are accepted every cycle.
- IDLE, `read & ~hit`:
  - At the edge, `mem_address <=` address tag, `mem_read <= 1`, `beat <= 0`.
  - Go to FILL. The tag is sampled here, so later `address` changes do not affect the fill.
- FILL:
  - Each cycle with `mem_rvalid`, `line[beat] <= mem_rdata` and `beat <= beat+1`.
  - On the beat with `beat == WORDS-1`, set `tag <=` sampled tag and `valid <= 1`, deassert `mem_read`, and return to IDLE.
  - Gaps in `mem_rvalid` simply hold the state.
- While in FILL, `valid` is forced to 0. A partially written line is never served.
- `flush`:
  - In IDLE, `valid <= 0` at the edge; it overrides a simultaneous hit, so that cycle gives no hit and `busywait = read`.
  - In FILL, the burst is aborted: `mem_read <= 0`, state returns to IDLE, `valid` stays 0, and the in-flight beat is dropped. If `read` is still high, a new miss is issued next cycle.
- `read` low: no state change and no `instr_valid`. Deasserting `read` mid-FILL does not abort the fill.
- `instr_valid` is 0 in every cycle that does not follow an accepted hit. `instruction` holds its last value.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `valid` 0, `beat` 0, `instruction` 0, `instr_valid` 0, `mem_read` 0, `mem_address` 0. Line contents are not reset.
- Reset mid-FILL: the fill is abandoned immediately and `mem_read` drops asynchronously.
- Hit latency: `read` sampled at edge N gives `instruction`/`instr_valid` valid after edge N. `busywait` is low throughout cycle N.
- Miss latency with memory returning beats every cycle:
  - Miss edge N sets `mem_read`.
  - Beats are sampled at edges N+1..N+WORDS; IDLE is re-entered after edge N+WORDS.
  - Cycle N+WORDS+1 is a hit; `instr_valid` appears after edge N+WORDS+1.
  - `busywait` is high for WORDS+1 cycles.
- `mem_read` and `mem_address` are stable for the whole burst.

## Test plan
1. Reset, then `read`=1, `address`=0x004 (tag 1, offset 0), memory returns beats A0..A3 back-to-back -> `mem_read`=1 with `mem_address`=0x001 for 4 cycles; `busywait` high for 5 cycles; then `instruction`=A0 with a 1-cycle `instr_valid`.
2. After test 1, hits at addresses 0x005, 0x006, 0x007 in consecutive cycles -> `busywait`=0 throughout; `instruction` = A1, A2, A3 on successive cycles; no `mem_read`.
3. Miss at 0x008 with `mem_rvalid` gaps (pattern 1,0,1,1,0,1) -> line filled in order; `busywait` high until the cycle after the 4th beat; correct word returned.
4. `flush` pulsed on the 2nd fill beat with `read` held -> `mem_read` drops; re-miss next cycle with the same `mem_address`; the final word comes from the second burst.
5. `flush` in IDLE concurrent with a hitting `read` -> no `instr_valid` that cycle; `busywait`=1; a new miss follows.
6. Assert `reset`=0 mid-FILL, then release -> all outputs at reset values immediately; first `read` afterwards misses.
